// File: rtl/redirect_ctrl_pkg.sv
// Shared types and constants for the redirect/flush sequencer.
// ROB_DEPTH = 2**ROB_W; epochs wrap modulo 2**EPOCH_W.
package redirect_ctrl_pkg;

    localparam int ROB_W     = 4;
    localparam int EPOCH_W   = 2;
    localparam int SRC_IDX_W = 2;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FLUSH,
        RD_DRAIN,
        RD_REDIR
    } redir_state_e;

    // Distance from the ROB head; smaller means older.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                                 input logic [ROB_W-1:0] head);
        return idx - head;
    endfunction

endpackage

// File: rtl/redirect_ctrl_age_sel.sv
// Oldest-eligible redirect picker: epoch filter plus ROB-age priority, ties to lowest index.
module redirect_ctrl_age_sel
    import redirect_ctrl_pkg::*;
#(
    parameter int NSRC = 2
) (
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*ROB_W-1:0]   src_rob_idx,
    input  logic [NSRC*EPOCH_W-1:0] src_epoch,
    input  logic [ROB_W-1:0]        rob_head,
    input  logic [EPOCH_W-1:0]      cur_epoch,
    input  logic                    seq_active,
    input  logic [ROB_W-1:0]        pend_age,
    output logic                    win_valid,
    output logic [SRC_IDX_W-1:0]    win_idx
);

    logic [EPOCH_W-1:0] prev_epoch;
    logic [ROB_W-1:0]   best_age;
    logic [ROB_W-1:0]   age;
    logic [EPOCH_W-1:0] ep;
    logic               elig;

    assign prev_epoch = cur_epoch - EPOCH_W'(1);

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        best_age  = '0;
        age       = '0;
        ep        = '0;
        elig      = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            age  = rob_age(src_rob_idx[i*ROB_W +: ROB_W], rob_head);
            ep   = src_epoch[i*EPOCH_W +: EPOCH_W];
            // Previous-epoch requests only matter if they are older than what is in flight.
            elig = src_valid[i] &&
                   ((ep == cur_epoch) ||
                    (seq_active && (ep == prev_epoch) && (age < pend_age)));
            if (elig && (!win_valid || (age < best_age))) begin
                win_valid = 1'b1;
                win_idx   = SRC_IDX_W'(i);
                best_age  = age;
            end
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// Redirect/flush sequencer: picks the oldest live redirect, bumps the epoch,
// pulses a backend flush, drains, then steers fetch to the new PC.
module redirect_ctrl
    import redirect_ctrl_pkg::*;
#(
    parameter int NSRC         = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NSRC-1:0]         src_valid,
    input  logic [NSRC*32-1:0]      src_pc,
    input  logic [NSRC*ROB_W-1:0]   src_rob_idx,
    input  logic [NSRC*EPOCH_W-1:0] src_epoch,
    input  logic [ROB_W-1:0]        rob_head,
    output logic [EPOCH_W-1:0]      cur_epoch,
    output logic                    flush_valid,
    output logic [ROB_W-1:0]        flush_rob_idx,
    output logic                    fetch_redirect_valid,
    output logic [31:0]             fetch_redirect_pc,
    input  logic                    fetch_redirect_ready,
    output logic                    busy
);

    // state    | meaning
    // RD_IDLE  | no redirect in flight
    // RD_FLUSH | one-cycle backend flush pulse
    // RD_DRAIN | wait FLUSH_CYCLES cycles for the backend to settle
    // RD_REDIR | present new PC to fetch until accepted

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    redir_state_e        state, state_nxt;
    logic [31:0]         pend_pc;
    logic [ROB_W-1:0]    pend_rob_idx;
    logic [ROB_W-1:0]    pend_age;
    logic [CNT_W-1:0]    cnt;
    logic                win_valid;
    logic [SRC_IDX_W-1:0] win_idx;
    logic [31:0]         win_pc;
    logic [ROB_W-1:0]    win_rob;

    // Head keeps moving while the flush retires, so age is re-derived every cycle.
    assign pend_age = rob_age(pend_rob_idx, rob_head);
    assign busy     = (state != RD_IDLE);

    redirect_ctrl_age_sel #(.NSRC(NSRC)) u_age_sel (
        .src_valid   (src_valid),
        .src_rob_idx (src_rob_idx),
        .src_epoch   (src_epoch),
        .rob_head    (rob_head),
        .cur_epoch   (cur_epoch),
        .seq_active  (busy),
        .pend_age    (pend_age),
        .win_valid   (win_valid),
        .win_idx     (win_idx)
    );

    always_comb begin
        win_pc  = '0;
        win_rob = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (win_idx == SRC_IDX_W'(i)) begin
                win_pc  = src_pc[i*32 +: 32];
                win_rob = src_rob_idx[i*ROB_W +: ROB_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RD_IDLE;
            cur_epoch    <= '0;
            pend_pc      <= '0;
            pend_rob_idx <= '0;
            cnt          <= '0;
        end else begin
            state <= state_nxt;
            if (win_valid) begin
                pend_pc      <= win_pc;
                pend_rob_idx <= win_rob;
                cur_epoch    <= cur_epoch + EPOCH_W'(1);
            end
            if (state == RD_FLUSH) begin
                cnt <= CNT_W'(FLUSH_CYCLES - 1);
            end else if ((state == RD_DRAIN) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt            = state;
        flush_valid          = 1'b0;
        flush_rob_idx        = '0;
        fetch_redirect_valid = 1'b0;
        fetch_redirect_pc    = '0;
        case (state)
            RD_IDLE: ;
            RD_FLUSH: begin
                flush_valid   = 1'b1;
                flush_rob_idx = pend_rob_idx;
                state_nxt     = RD_DRAIN;
            end
            RD_DRAIN: begin
                if (cnt == '0) state_nxt = RD_REDIR;
            end
            RD_REDIR: begin
                fetch_redirect_valid = 1'b1;
                fetch_redirect_pc    = pend_pc;
                if (fetch_redirect_ready) state_nxt = RD_IDLE;
            end
            default: state_nxt = RD_IDLE;
        endcase
        // A new accepted redirect always restarts the sequence, even over a fetch fire.
        if (win_valid) state_nxt = RD_FLUSH;
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Self-checking bench for redirect_ctrl: directed scenarios plus random traffic
// compared against a timeline model of the redirect sequence.
module tb_redirect_ctrl;
    import redirect_ctrl_pkg::*;

    localparam int NSRC  = 2;
    localparam int FC    = 2;
    localparam int DEPTH = 1 << ROB_W;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NSRC-1:0]         src_valid = '0;
    logic [NSRC*32-1:0]      src_pc = '0;
    logic [NSRC*ROB_W-1:0]   src_rob_idx = '0;
    logic [NSRC*EPOCH_W-1:0] src_epoch = '0;
    logic [ROB_W-1:0]        rob_head = '0;
    logic [EPOCH_W-1:0]      cur_epoch;
    logic                    flush_valid;
    logic [ROB_W-1:0]        flush_rob_idx;
    logic                    fetch_redirect_valid;
    logic [31:0]             fetch_redirect_pc;
    logic                    fetch_redirect_ready = 1'b0;
    logic                    busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a redirect accepted at cycle A flushes at A+1, presents to fetch from A+2+FC until fire.
    bit m_active = 0;
    int m_acc_cyc = 0;
    int m_epoch = 0;
    int m_pc = 0;
    int m_rob = 0;
    int cyc = 0;

    redirect_ctrl #(.NSRC(NSRC), .FLUSH_CYCLES(FC)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .src_valid            (src_valid),
        .src_pc               (src_pc),
        .src_rob_idx          (src_rob_idx),
        .src_epoch            (src_epoch),
        .rob_head             (rob_head),
        .cur_epoch            (cur_epoch),
        .flush_valid          (flush_valid),
        .flush_rob_idx        (flush_rob_idx),
        .fetch_redirect_valid (fetch_redirect_valid),
        .fetch_redirect_pc    (fetch_redirect_pc),
        .fetch_redirect_ready (fetch_redirect_ready),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_src(input int i, input bit v, input int rob, input int ep, input int pc);
        src_valid[i]                  = v;
        src_rob_idx[i*ROB_W +: ROB_W] = ROB_W'(rob);
        src_epoch[i*EPOCH_W +: EPOCH_W] = EPOCH_W'(ep);
        src_pc[i*32 +: 32]            = 32'(pc);
    endtask

    task automatic clr_src();
        src_valid = '0;
    endtask

    task automatic model_reset();
        m_active = 0;
        m_epoch  = 0;
    endtask

    // One clock: check outputs at negedge, predict, then advance the model after the edge.
    task automatic cycle();
        int  since, best, best_age, age, ep, pend_age;
        bit  e_flush, e_redir, elig, fire;
        @(negedge clk);
        since   = cyc - m_acc_cyc;
        e_flush = m_active && (since == 1);
        e_redir = m_active && (since >= 2 + FC);
        chk("busy", 32'(busy), 32'(m_active));
        chk("epoch", 32'(cur_epoch), 32'(m_epoch));
        chk("flush_valid", 32'(flush_valid), 32'(e_flush));
        chk("flush_idx", 32'(flush_rob_idx), e_flush ? 32'(m_rob) : 32'd0);
        chk("fetch_valid", 32'(fetch_redirect_valid), 32'(e_redir));
        chk("fetch_pc", fetch_redirect_pc, e_redir ? 32'(m_pc) : 32'd0);
        pend_age = (m_rob - int'(rob_head) + DEPTH) % DEPTH;
        best = -1;
        best_age = DEPTH;
        for (int i = 0; i < NSRC; i++) begin
            age  = (int'(src_rob_idx[i*ROB_W +: ROB_W]) - int'(rob_head) + DEPTH) % DEPTH;
            ep   = int'(src_epoch[i*EPOCH_W +: EPOCH_W]);
            elig = src_valid[i] && ((ep == m_epoch) ||
                   (m_active && (ep == (m_epoch + 3) % 4) && (age < pend_age)));
            if (elig && age < best_age) begin
                best = i;
                best_age = age;
            end
        end
        fire = e_redir && fetch_redirect_ready;
        @(posedge clk);
        #1;
        if (best >= 0) begin
            m_pc      = int'(src_pc[best*32 +: 32]);
            m_rob     = int'(src_rob_idx[best*ROB_W +: ROB_W]);
            m_epoch   = (m_epoch + 1) % 4;
            m_acc_cyc = cyc;
            m_active  = 1;
        end else if (fire) begin
            m_active = 0;
        end
        cyc++;
    endtask

    task automatic run_to_idle();
        int n = 0;
        clr_src();
        fetch_redirect_ready = 1'b1;
        while (m_active && n < 20) begin
            cycle();
            n++;
        end
        chk("idle_timeout", 32'(m_active), 32'd0);
        cycle();
    endtask

    task automatic one_redirect(input int rob, input int pc);
        rob_head = '0;
        set_src(0, 1, rob, m_epoch, pc);
        cycle();
        run_to_idle();
    endtask

    initial begin
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_epoch", 32'(cur_epoch), 32'd0);
        chk("rst_flush", 32'(flush_valid), 32'd0);
        chk("rst_fetch", 32'(fetch_redirect_valid), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic latency, then 5: held redirect under back-pressure.
        rob_head = 4'd0;
        fetch_redirect_ready = 1'b0;
        set_src(0, 1, 5, 0, 32'h100);
        cycle();
        clr_src();
        chk("t1_flush", 32'(flush_valid), 32'd1);
        chk("t1_idx", 32'(flush_rob_idx), 32'd5);
        chk("t1_epoch", 32'(cur_epoch), 32'd1);
        repeat (3) cycle();
        chk("t1_redir", 32'(fetch_redirect_valid), 32'd1);
        chk("t1_pc", fetch_redirect_pc, 32'h100);
        repeat (5) cycle();
        chk("t5_hold_valid", 32'(fetch_redirect_valid), 32'd1);
        chk("t5_hold_pc", fetch_redirect_pc, 32'h100);
        fetch_redirect_ready = 1'b1;
        cycle();
        chk("t5_busy", 32'(busy), 32'd0);
        cycle();

        // 2: same-cycle pair, older (by age from head) wins.
        rob_head = 4'd2;
        set_src(0, 1, 9, 1, 32'h900);
        set_src(1, 1, 3, 1, 32'h300);
        cycle();
        clr_src();
        chk("t2_idx", 32'(flush_rob_idx), 32'd3);
        run_to_idle();
        chk("t2_epoch", 32'(cur_epoch), 32'd2);

        // 3: older previous-epoch branch supersedes during DRAIN; younger one dropped.
        rob_head = 4'd2;
        set_src(0, 1, 8, 2, 32'h800);
        cycle();
        clr_src();
        cycle();
        set_src(0, 1, 4, 2, 32'h400);
        cycle();
        clr_src();
        chk("t3_flush", 32'(flush_valid), 32'd1);
        chk("t3_idx", 32'(flush_rob_idx), 32'd4);
        chk("t3_epoch", 32'(cur_epoch), 32'd0);
        cycle();
        set_src(0, 1, 12, 3, 32'hC00);
        cycle();
        clr_src();
        chk("t3_drop", 32'(flush_valid), 32'd0);
        run_to_idle();

        // 4: wrap of ROB age and of the epoch counter.
        while (m_epoch != 3) one_redirect(1, 32'h40);
        rob_head = 4'd14;
        set_src(0, 1, 1, 3, 32'h111);
        set_src(1, 1, 15, 3, 32'hFFF);
        cycle();
        clr_src();
        chk("t4_idx", 32'(flush_rob_idx), 32'd15);
        chk("t4_epoch_wrap", 32'(cur_epoch), 32'd0);
        run_to_idle();

        // 6: stale epoch ignored in IDLE; reset mid-DRAIN clears everything.
        set_src(0, 1, 6, 2, 32'h600);
        cycle();
        clr_src();
        chk("t6_stale", 32'(busy), 32'd0);
        set_src(0, 1, 6, 0, 32'h600);
        cycle();
        clr_src();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_epoch", 32'(cur_epoch), 32'd0);
        chk("t6_rst_flush", 32'(flush_valid), 32'd0);
        chk("t6_rst_fetch", 32'(fetch_redirect_valid), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int pick;
            for (int i = 0; i < NSRC; i++) begin
                pick = $urandom_range(0, 9);
                set_src(i, ($urandom_range(0, 5) == 0),
                        $urandom_range(0, DEPTH - 1),
                        (pick < 6) ? m_epoch : (pick < 9) ? (m_epoch + 3) % 4 : $urandom_range(0, 3),
                        $urandom);
            end
            if ($urandom_range(0, 3) == 0) rob_head = ROB_W'($urandom_range(0, DEPTH - 1));
            fetch_redirect_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end
        run_to_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
